// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard FIFO: port addresses, default depth
// and status-byte layout used by the CPU port router.
package kbd_pkg;

  localparam int          KBD_DEPTH_LOG2 = 4;
  localparam logic [15:0] KBD_PORT_DATA  = 16'h22;
  localparam logic [15:0] KBD_PORT_STAT  = 16'h23;

  localparam int STAT_OVF  = 7;
  localparam int STAT_FULL = 6;

  // Status byte as seen on KBD_PORT_STAT: {overflow, full, 0, count[4:0]}.
  function automatic logic [7:0] kbd_status(input logic       ovf,
                                            input logic       full,
                                            input logic [4:0] cnt);
    logic [7:0] s;
    s            = {3'b000, cnt};
    s[STAT_OVF]  = ovf;
    s[STAT_FULL] = full;
    return s;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
// Used for read-side-effect ports where a held read must act only once.
module edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i && !level_q;

endmodule

// File: rtl/kbd_fifo.sv
// Scancode FIFO between the PS/2 receiver and the CPU port router, with a
// zero-latency head output, sticky overflow and a per-new-head irq strobe.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = KBD_DEPTH_LOG2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  kb_done,
  input  logic [7:0]            kb_data,
  input  logic                  rd_req,
  input  logic                  clr,
  output logic [7:0]            q,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_q, irq_d;
  logic          pop, pop_ok, push_ok;
  logic          empty_w, full_w;

  edge_pulse u_rd_edge (
    .clock   (clock),
    .reset   (reset),
    .level_i (rd_req),
    .pulse_o (pop)
  );

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty_w;
  assign push_ok = kb_done && (!full_w || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_d      = 1'b0;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      if (kb_done && !push_ok) begin
        overflow_d = 1'b1;
      end
      // New head: first byte into an empty FIFO, or a pop exposing the next byte.
      irq_d = (push_ok && empty_w) || (pop_ok && (count_d != '0));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_ok && !clr) begin
      mem_q[wr_ptr_q] <= kb_data;
    end
  end

  assign q        = empty_w ? 8'h00 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// Directed bench for kbd_fifo: stimulus queues the head byte expected with
// each irq; a monitor pops and compares whenever irq is seen.
module tb_kbd_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       kb_done;
  logic [7:0] kb_data;
  logic       rd_req;
  logic       clr;
  logic [7:0] q;
  logic [4:0] count;
  logic       empty, full, overflow, irq;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_irq_q[$];
  bit         mon_run = 1'b1;

  kbd_fifo #(.DEPTH_LOG2(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .kb_done  (kb_done),
    .kb_data  (kb_data),
    .rd_req   (rd_req),
    .clr      (clr),
    .q        (q),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    while (mon_run) begin
      @(negedge clock);
      if (irq === 1'b1) begin
        if (exp_irq_q.size() == 0) begin
          check("unexpected_irq", 32'(q), 32'hFFFF_FFFF);
        end else begin
          e = exp_irq_q.pop_front();
          check("irq_head", 32'(q), 32'(e));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    kb_done = 1'b1;
    kb_data = b;
    step();
    kb_done = 1'b0;
  endtask

  // Hold rd_req for n cycles, then drop it for one cycle so the next rise is an edge.
  task automatic pop(input int n);
    rd_req = 1'b1;
    repeat (n) step();
    rd_req = 1'b0;
    step();
  endtask

  task automatic push_pop(input logic [7:0] b);
    kb_done = 1'b1;
    kb_data = b;
    rd_req  = 1'b1;
    step();
    kb_done = 1'b0;
    rd_req  = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b1;
    kb_done = 1'b0;
    kb_data = 8'h00;
    rd_req  = 1'b0;
    clr     = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) step();
    reset = 1'b0;

    check("rst_q", 32'(q), 32'h00);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_irq", 32'(irq), 0);

    // Single push into empty FIFO.
    exp_irq_q.push_back(8'h1C);
    push(8'h1C);
    check("p1_count", 32'(count), 1);
    check("p1_q", 32'(q), 32'h1C);
    check("p1_empty", 32'(empty), 0);
    pop(1);
    check("p1_drained", 32'(empty), 1);

    // Held rd_req pops exactly once.
    exp_irq_q.push_back(8'h1C);
    push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    exp_irq_q.push_back(8'hF0);
    pop(5);
    check("hold_q", 32'(q), 32'hF0);
    check("hold_count", 32'(count), 2);
    exp_irq_q.push_back(8'h1C);
    pop(1);
    check("repop_q", 32'(q), 32'h1C);
    check("repop_count", 32'(count), 1);
    pop(1);
    check("repop_empty", 32'(empty), 1);

    // Overfill by one, then drain.
    exp_irq_q.push_back(8'h00);
    for (int i = 0; i <= 16; i++) push(8'(i));
    check("fill_count", 32'(count), 16);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_q", 32'(q), 32'(i));
      if (i < 15) exp_irq_q.push_back(8'(i + 1));
      pop(1);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_q0", 32'(q), 32'h00);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // clr with a coincident byte: everything flushed, byte discarded.
    exp_irq_q.push_back(8'h61);
    push(8'h61);
    push(8'h62);
    push(8'h63);
    check("pre_clr_count", 32'(count), 3);
    clr     = 1'b1;
    kb_done = 1'b1;
    kb_data = 8'h77;
    step();
    clr     = 1'b0;
    kb_done = 1'b0;
    step();
    check("clr_count", 32'(count), 0);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_q", 32'(q), 32'h00);
    check("clr_empty", 32'(empty), 1);

    // Full FIFO: push coinciding with pop is accepted.
    exp_irq_q.push_back(8'h20);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("full2_count", 32'(count), 16);
    check("full2_ovf", 32'(overflow), 0);
    exp_irq_q.push_back(8'h21);
    push_pop(8'hAA);
    check("fpp_count", 32'(count), 16);
    check("fpp_ovf", 32'(overflow), 0);
    check("fpp_q", 32'(q), 32'h21);
    for (int i = 0; i < 16; i++) begin
      check("fpp_drain_q", 32'(q), (i < 15) ? 32'(8'h21 + i) : 32'hAA);
      if (i < 14) exp_irq_q.push_back(8'(8'h22 + i));
      else if (i == 14) exp_irq_q.push_back(8'hAA);
      pop(1);
    end
    check("fpp_empty", 32'(empty), 1);

    // Empty FIFO: push coinciding with a pop edge.
    exp_irq_q.push_back(8'h5A);
    push_pop(8'h5A);
    check("epp_count", 32'(count), 1);
    check("epp_q", 32'(q), 32'h5A);
    pop(1);
    check("epp_empty", 32'(empty), 1);

    // Pointer wrap with push/pop pairs.
    for (int i = 0; i < 40; i++) begin
      exp_irq_q.push_back(8'(8'h80 + i));
      push(8'(8'h80 + i));
      check("wrap_q", 32'(q), 32'(8'h80 + i));
      pop(1);
    end
    check("wrap_empty", 32'(empty), 1);

    repeat (3) step();
    mon_run = 1'b0;
    @(negedge clock);
    check("irq_all_seen", 32'(exp_irq_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
